rv32i_core: RTL and testbench
=============================

# rv32i_core

Single-cycle RV32I integer core that executes one instruction per clock. Instructions are fetched from an asynchronous-read instruction memory, and loads/stores go to a byte-lane data memory (4 bytes per access, one write enable). The core sits inside the machine wrapper, between the instruction memory and the data memory. It raises `halted` on ECALL/EBREAK so that the wrapper ends simulation.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock.
- `rst_b`  input  1  reset; asynchronous, active-low.
- `inst`  input  32  instruction at `inst_addr`; little-endian word assembled by the wrapper.
- `inst_addr`  output  32  PC, a byte address.
- `mem_addr`  output  32  data byte address, equal to rs1+imm.
- `mem_data_out`  input  4×8 (`[0:3]`)  bytes at `mem_addr+0..+3`, read combinationally from data memory.
- `mem_data_in`  output  4×8 (`[0:3]`)  bytes written to `mem_addr+0..+3`.
- `mem_write_en`  output  1  data memory write strobe; the memory writes all 4 bytes on the next rising edge.
- `halted`  output  1  sticky halt flag.

## Operation
- State:
  - PC (32 bits).
  - 31 general registers; x0 reads 0 and writes to it are discarded.
  - `halted` flag.
- Supported instructions (full RV32I base):
  - LUI, AUIPC, JAL, JALR. JALR target = (rs1+imm) & ~1.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU.
  - SB, SH, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Immediate formats: I, S, B, U and J, all sign-extended per the ISA. Shift amounts use the low 5 bits.
- Loads: byte k comes from `mem_data_out[k]`. The word is {b3,b2,b1,b0}. LB/LH sign-extend; LBU/LHU zero-extend.
- Stores: `mem_data_in[k]` = rs2 byte k for the written lanes. Unwritten lanes pass `mem_data_out[k]` through (read-modify-write).
  - SB writes lane 0.
  - SH writes lanes 0–1.
  - SW writes lanes 0–3.
- Misaligned addresses raise no exception; the access uses exactly `mem_addr..mem_addr+3`.
- Next PC:
  - PC+4 by default.
  - PC+imm for a taken branch or JAL.
  - The JALR target for JALR.
  - JAL/JALR write PC+4 to rd.
- FENCE, and any opcode not listed above, execute as a NOP (PC+4, no register or memory write).
- ECALL or EBREAK sets `halted`. That instruction writes nothing.
- While `halted`=1:
  - PC is frozen.
  - Register writes are suppressed.
  - `mem_write_en` is 0.
- Arithmetic is 32-bit wrap-around; overflow is ignored.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
  - SLTIU sign-extends its immediate, then compares unsigned.

## Timing
- Reset (`rst_b`=0, asynchronous):
  - PC=0 and `inst_addr`=0.
  - All registers = 0.
  - `halted`=0 and `mem_write_en`=0.
  - `mem_addr` and `mem_data_in` follow the combinational decode of `inst`. They are don't-care while in reset.
- Asserting reset mid-program aborts the current instruction; no write occurs on that edge.
- Single cycle per instruction:
  - Decode, register read, ALU, data-memory read and the store merge are combinational within the cycle.
  - PC, the register file and `halted` update on the rising edge.
  - The memory write commits on the same edge.
- Load-use needs no stall: the loaded value is visible to the next instruction.
- `halted` rises on the edge that retires ECALL and remains 1 until reset.
- A register read in the same cycle as a write to that register returns the old value; the new value is visible the next cycle.

## Test plan
- Reset, then release → `inst_addr`=0. With ADDI x1,x0,5 at addr 0, on the next edge x1=5 and `inst_addr`=4.
- Arithmetic: x1=-8 then SRAI x2,x1,1 → x2=0xFFFFFFFC. SRLI → 0x7FFFFFFC. SLTU x3,x0,x1 → 1. SLT x4,x1,x0 → 1.
- Memory sequence:
  - SW 0x11223344 at addr 0x100 → `mem_data_in`={44,33,22,11}, `mem_write_en`=1 for one cycle.
  - SB 0xAA to addr 0x100 → lanes 1–3 pass through unchanged.
  - LW then reads back 0x112233AA; LB reads 0xFFFFFFAA; LBU reads 0x000000AA.
- Control flow:
  - BEQ taken (+8) and BNE not-taken each redirect correctly.
  - JAL x1,+16 at PC 0x20 → x1=0x24, PC=0x30.
  - JALR x0,0(x1) with x1=0x25 → PC=0x24.
- Writes to x0 are discarded: ADDI x0,x0,7, then ADD x5,x0,x0 → x5=0.
- ECALL at PC 0x40 → `halted`=1 after that edge. PC stays 0x40 and `mem_write_en`=0 on later cycles, even if the next word is a store.

Source files
------------

// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I integer core.
// One instruction retires per clock; ECALL/EBREAK halt.
module rv32i_core (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_data_out [0:3],
  output logic [7:0]  mem_data_in  [0:3],
  output logic        mem_write_en,
  output logic        halted
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [31:0] pc;
  logic [31:0] regs [0:31];

  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] rv1;
  logic [31:0] rv2;

  assign opc = inst[6:0];
  assign rd  = inst[11:7];
  assign f3  = inst[14:12];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25],
                  inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};
  assign imm_j = {{11{inst[31]}}, inst[31],
                  inst[19:12], inst[20],
                  inst[30:21], 1'b0};

  assign rv1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rv2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  logic is_lui;
  logic is_auipc;
  logic is_jal;
  logic is_jalr;
  logic is_br;
  logic is_ld;
  logic is_st;
  logic is_imm;
  logic is_reg;
  logic is_halt;

  assign is_lui   = (opc == OP_LUI);
  assign is_auipc = (opc == OP_AUIPC);
  assign is_jal   = (opc == OP_JAL);
  assign is_jalr  = (opc == OP_JALR);
  assign is_br    = (opc == OP_BR);
  assign is_imm   = (opc == OP_IMM);
  assign is_reg   = (opc == OP_REG);
  assign is_ld    = (opc == OP_LD) &&
                    (f3 != 3'd3) && (f3 < 3'd6);
  assign is_st    = (opc == OP_ST) && (f3 < 3'd3);
  assign is_halt  = (inst == 32'h0000_0073) ||
                    (inst == 32'h0010_0073);

  // ALU shared by OP and OP-IMM
  logic [31:0] alu_b;
  logic [31:0] alu_r;
  logic        alt;
  logic [4:0]  sh;

  assign alu_b = is_reg ? rv2 : imm_i;
  assign alt   = inst[30];
  assign sh    = alu_b[4:0];

  // ALU result per funct3
  always_comb begin
    alu_r = 32'd0;
    case (f3)
      3'd0: alu_r = (is_reg && alt) ? rv1 - alu_b
                                    : rv1 + alu_b;
      3'd1: alu_r = rv1 << sh;
      3'd2: alu_r = {31'd0,
                     $signed(rv1) < $signed(alu_b)};
      3'd3: alu_r = {31'd0, rv1 < alu_b};
      3'd4: alu_r = rv1 ^ alu_b;
      3'd5: alu_r = alt ? $unsigned($signed(rv1) >>> sh)
                        : rv1 >> sh;
      3'd6: alu_r = rv1 | alu_b;
      3'd7: alu_r = rv1 & alu_b;
      default: alu_r = 32'd0;
    endcase
  end

  // branch condition per funct3
  logic taken;
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'd0: taken = (rv1 == rv2);
      3'd1: taken = (rv1 != rv2);
      3'd4: taken = $signed(rv1) < $signed(rv2);
      3'd5: taken = $signed(rv1) >= $signed(rv2);
      3'd6: taken = rv1 < rv2;
      3'd7: taken = rv1 >= rv2;
      default: taken = 1'b0;
    endcase
  end

  assign mem_addr = rv1 + (is_st ? imm_s : imm_i);

  logic [31:0] ld_word;
  logic [31:0] ld_val;
  assign ld_word = {mem_data_out[3], mem_data_out[2],
                    mem_data_out[1], mem_data_out[0]};

  // load extraction and extension
  always_comb begin
    ld_val = ld_word;
    case (f3)
      3'd0: ld_val = {{24{ld_word[7]}}, ld_word[7:0]};
      3'd1: ld_val = {{16{ld_word[15]}}, ld_word[15:0]};
      3'd4: ld_val = {24'd0, ld_word[7:0]};
      3'd5: ld_val = {16'd0, ld_word[15:0]};
      default: ld_val = ld_word;
    endcase
  end

  // store merge: unwritten lanes pass the old bytes
  always_comb begin
    mem_data_in[0] = rv2[7:0];
    mem_data_in[1] = (f3 != 3'd0) ? rv2[15:8]
                                  : mem_data_out[1];
    mem_data_in[2] = (f3 == 3'd2) ? rv2[23:16]
                                  : mem_data_out[2];
    mem_data_in[3] = (f3 == 3'd2) ? rv2[31:24]
                                  : mem_data_out[3];
  end

  assign mem_write_en = is_st && !halted && rst_b;

  // writeback select
  logic [31:0] rd_val;
  logic        rd_we;
  always_comb begin
    rd_val = 32'd0;
    unique case (1'b1)
      is_lui:            rd_val = imm_u;
      is_auipc:          rd_val = pc + imm_u;
      is_jal, is_jalr:   rd_val = pc + 32'd4;
      is_ld:             rd_val = ld_val;
      is_imm, is_reg:    rd_val = alu_r;
      default:           rd_val = 32'd0;
    endcase
  end

  assign rd_we = (is_lui || is_auipc || is_jal ||
                  is_jalr || is_ld || is_imm ||
                  is_reg) && (rd != 5'd0);

  // next PC select
  logic [31:0] next_pc;
  always_comb begin
    next_pc = pc + 32'd4;
    unique case (1'b1)
      is_halt:         next_pc = pc;
      is_jal:          next_pc = pc + imm_j;
      is_jalr:         next_pc = (rv1 + imm_i) &
                                 32'hFFFF_FFFE;
      is_br && taken:  next_pc = pc + imm_b;
      default:         next_pc = pc + 32'd4;
    endcase
  end

  assign inst_addr = pc;

  // architectural state; frozen once halted
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pc     <= 32'd0;
      halted <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (!halted) begin
      pc <= next_pc;
      if (is_halt) halted <= 1'b1;
      if (rd_we) regs[rd] <= rd_val;
    end
  end

endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed programs checked against an
// instruction-level reference interpreter plus literals.
module tb_rv32i_core;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_out [0:3];
  logic [7:0]  mem_data_in  [0:3];
  logic        mem_write_en;
  logic        halted;

  rv32i_core dut (
    .clk(clk), .rst_b(rst_b), .inst(inst),
    .inst_addr(inst_addr), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:63];
  logic [7:0]  dmem [0:1023];

  assign inst = imem[inst_addr[7:2]];

  always_comb begin
    for (int k = 0; k < 4; k++)
      mem_data_out[k] = dmem[mem_addr[9:0] + 10'(k)];
  end

  always @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= 8'h00;
    end else if (mem_write_en) begin
      for (int k = 0; k < 4; k++)
        dmem[mem_addr[9:0] + 10'(k)] <= mem_data_in[k];
    end
  end

  wire [31:0] din_w = {mem_data_in[3], mem_data_in[2],
                       mem_data_in[1], mem_data_in[0]};

  int total = 0;
  int bad = 0;
  int prog = 0;
  int cyc = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s prog=%0d cyc=%0d got=%h want=%h",
               nm, prog, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ei(
      input logic [31:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] er(
      input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3,
      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] es(
      input logic [31:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] eb(
      input logic [31:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] ej(
      input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, 7'h6f};
  endfunction

  function automatic logic [31:0] addi(
      input logic [4:0] rd, input logic [4:0] rs1,
      input logic [31:0] imm);
    return ei(imm, rs1, 3'd0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] sw(
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [31:0] imm);
    return es(imm, rs2, rs1, 3'd2);
  endfunction

  localparam logic [31:0] ECALL = 32'h0000_0073;

  task automatic load(input int p);
    for (int i = 0; i < 64; i++) imem[i] = 32'h13;
    case (p)
      0: begin
        imem[0]  = addi(1, 0, 5);
        imem[1]  = sw(1, 0, 32'h80);
        imem[2]  = addi(1, 0, -8);
        imem[3]  = ei(32'h401, 1, 3'd5, 2, 7'h13);
        imem[4]  = ei(32'h001, 1, 3'd5, 3, 7'h13);
        imem[5]  = er(7'h00, 1, 0, 3'd3, 4);
        imem[6]  = er(7'h00, 0, 1, 3'd2, 5);
        imem[7]  = sw(2, 0, 32'h80);
        imem[8]  = sw(3, 0, 32'h84);
        imem[9]  = sw(4, 0, 32'h88);
        imem[10] = sw(5, 0, 32'h8c);
        imem[11] = addi(0, 0, 7);
        imem[12] = er(7'h00, 0, 0, 3'd0, 6);
        imem[13] = sw(6, 0, 32'h90);
        imem[14] = {20'h12345, 5'd7, 7'h37};
        imem[15] = addi(7, 7, 32'h678);
        imem[16] = er(7'h20, 7, 0, 3'd0, 8);
        imem[17] = ei(-1, 7, 3'd4, 9, 7'h13);
        imem[18] = ei(32'h0f, 8, 3'd6, 10, 7'h13);
        imem[19] = ei(32'hff, 7, 3'd7, 11, 7'h13);
        imem[20] = er(7'h00, 4, 7, 3'd1, 12);
        imem[21] = er(7'h20, 5, 8, 3'd5, 13);
        imem[22] = ei(-1, 0, 3'd3, 14, 7'h13);
        imem[23] = {20'h00001, 5'd15, 7'h17};
        imem[24] = 32'h0000_000f;
        imem[25] = 32'hffff_ffff;
        imem[26] = sw(8, 0, 32'h94);
        imem[27] = sw(12, 0, 32'h98);
        imem[28] = sw(13, 0, 32'h9c);
        imem[29] = sw(14, 0, 32'ha0);
        imem[30] = sw(15, 0, 32'ha4);
        imem[31] = sw(9, 0, 32'ha8);
        imem[32] = sw(10, 0, 32'hac);
        imem[33] = sw(11, 0, 32'hb0);
        imem[34] = ei(0, 8, 3'd2, 16, 7'h13);
        imem[35] = sw(16, 0, 32'hb4);
        imem[36] = ECALL;
      end
      1: begin
        imem[0]  = {20'h11223, 5'd1, 7'h37};
        imem[1]  = addi(1, 1, 32'h344);
        imem[2]  = addi(2, 0, 32'h100);
        imem[3]  = sw(1, 2, 0);
        imem[4]  = addi(3, 0, 32'haa);
        imem[5]  = es(0, 3, 2, 3'd0);
        imem[6]  = ei(0, 2, 3'd2, 4, 7'h03);
        imem[7]  = ei(0, 2, 3'd0, 5, 7'h03);
        imem[8]  = ei(0, 2, 3'd4, 6, 7'h03);
        imem[9]  = sw(4, 2, 4);
        imem[10] = sw(5, 2, 8);
        imem[11] = sw(6, 2, 12);
        imem[12] = ei(0, 2, 3'd1, 7, 7'h03);
        imem[13] = ei(2, 2, 3'd5, 8, 7'h03);
        imem[14] = es(2, 3, 2, 3'd1);
        imem[15] = ei(1, 2, 3'd2, 9, 7'h03);
        imem[16] = sw(9, 2, 32'h10);
        imem[17] = ei(1, 2, 3'd1, 10, 7'h03);
        imem[18] = sw(10, 2, 32'h14);
        imem[19] = sw(7, 2, 32'h18);
        imem[20] = sw(8, 2, 32'h1c);
        imem[21] = ECALL;
      end
      default: begin
        imem[0]  = addi(1, 0, 1);
        imem[1]  = eb(8, 1, 1, 3'd0);
        imem[2]  = addi(2, 0, 99);
        imem[3]  = eb(8, 1, 1, 3'd1);
        imem[4]  = eb(8, 1, 0, 3'd4);
        imem[5]  = addi(2, 0, 98);
        imem[6]  = eb(64, 1, 0, 3'd7);
        imem[7]  = eb(64, 0, 1, 3'd6);
        imem[8]  = ej(16, 1);
        imem[9]  = ej(32'h1c, 0);
        imem[12] = sw(1, 0, 32'h80);
        imem[13] = addi(1, 1, 1);
        imem[14] = ei(0, 1, 3'd0, 0, 7'h67);
        imem[16] = ECALL;
        imem[17] = sw(1, 0, 0);
      end
    endcase
  endtask

  // reference interpreter state
  logic [31:0] m_x [0:31];
  logic [31:0] m_pc;
  logic        m_halt;
  logic [7:0]  m_mem [0:1023];

  logic [31:0] w, a, b, ii, is, ib, ij, wv, npc, ea, r;
  logic [31:0] lw, e_din;
  logic [6:0]  op;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic        wb, e_we, e_mem, hnow, t;
  int          n;

  // per-cycle reference step and comparison
  always @(negedge clk) begin
    if (!rst_b) begin
      m_pc = 0;
      m_halt = 0;
      cyc = 0;
      for (int i = 0; i < 32; i++) m_x[i] = 0;
      for (int i = 0; i < 1024; i++) m_mem[i] = 0;
      chk("rst_pc", inst_addr, 0);
      chk("rst_we", {31'd0, mem_write_en}, 0);
      chk("rst_halt", {31'd0, halted}, 0);
    end else begin
      w  = imem[m_pc[7:2]];
      op = w[6:0];
      rd = w[11:7];
      f3 = w[14:12];
      a  = m_x[w[19:15]];
      b  = m_x[w[24:20]];
      ii = {{20{w[31]}}, w[31:20]};
      is = {{20{w[31]}}, w[31:25], w[11:7]};
      ib = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      ij = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      wb = 0; wv = 0; e_we = 0; e_mem = 0; hnow = 0;
      ea = 0; e_din = 0; n = 0; npc = m_pc + 4;
      if (m_halt) npc = m_pc;
      else case (op)
        7'h37: begin wb = 1; wv = {w[31:12], 12'h0}; end
        7'h17: begin
          wb = 1; wv = m_pc + {w[31:12], 12'h0};
        end
        7'h6f: begin wb = 1; wv = m_pc + 4; npc = m_pc + ij; end
        7'h67: begin
          wb = 1; wv = m_pc + 4; npc = (a + ii) & ~32'd1;
        end
        7'h63: begin
          case (f3)
            0: t = a == b;
            1: t = a != b;
            4: t = $signed(a) < $signed(b);
            5: t = $signed(a) >= $signed(b);
            6: t = a < b;
            7: t = a >= b;
            default: t = 0;
          endcase
          if (t) npc = m_pc + ib;
        end
        7'h03: begin
          ea = a + ii;
          for (int k = 0; k < 4; k++)
            lw[8*k +: 8] = m_mem[ea[9:0] + 10'(k)];
          e_mem = 1;
          wb = 1;
          case (f3)
            0: wv = {{24{lw[7]}}, lw[7:0]};
            1: wv = {{16{lw[15]}}, lw[15:0]};
            2: wv = lw;
            4: wv = {24'd0, lw[7:0]};
            5: wv = {16'd0, lw[15:0]};
            default: begin wb = 0; e_mem = 0; end
          endcase
        end
        7'h23: begin
          ea = a + is;
          n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
          e_we = (n > 0);
          e_mem = e_we;
          for (int k = 0; k < 4; k++)
            e_din[8*k +: 8] = (k < n) ? b[8*k +: 8]
                              : m_mem[ea[9:0] + 10'(k)];
        end
        7'h13, 7'h33: begin
          r = (op == 7'h33) ? b : ii;
          case (f3)
            0: wv = (op == 7'h33 && w[30]) ? a - r : a + r;
            1: wv = a << r[4:0];
            2: wv = ($signed(a) < $signed(r)) ? 1 : 0;
            3: wv = (a < r) ? 1 : 0;
            4: wv = a ^ r;
            5: wv = w[30] ? $unsigned($signed(a) >>> r[4:0])
                          : a >> r[4:0];
            6: wv = a | r;
            default: wv = a & r;
          endcase
          wb = 1;
        end
        7'h73: if (w == ECALL || w == 32'h0010_0073) begin
          hnow = 1; npc = m_pc;
        end
        default: ;
      endcase

      chk("pc", inst_addr, m_pc);
      chk("halted", {31'd0, halted}, {31'd0, m_halt});
      chk("we", {31'd0, mem_write_en}, {31'd0, e_we});
      if (e_mem) chk("addr", mem_addr, ea);
      if (e_we) chk("din", din_w, e_din);

      case (prog)
        0: case (cyc)
          0:  chk("a_pc0", inst_addr, 0);
          1:  begin
                chk("a_pc4", inst_addr, 4);
                chk("a_addi", din_w, 5);
              end
          7:  chk("a_srai", din_w, 32'hFFFF_FFFC);
          8:  chk("a_srli", din_w, 32'h7FFF_FFFC);
          9:  chk("a_sltu", din_w, 1);
          10: chk("a_slt", din_w, 1);
          13: chk("a_x0", din_w, 0);
          26: chk("a_sub", din_w, 32'hEDCB_A988);
          27: chk("a_sll", din_w, 32'h2468_ACF0);
          28: chk("a_sra", din_w, 32'hF6E5_D4C4);
          29: chk("a_sltiu", din_w, 1);
          30: chk("a_auipc", din_w, 32'h105c);
          31: chk("a_xori", din_w, 32'hEDCB_A987);
          38: begin
                chk("a_halt", {31'd0, halted}, 1);
                chk("a_hpc", inst_addr, 32'h90);
              end
          default: ;
        endcase
        1: case (cyc)
          3:  begin
                chk("m_addr", mem_addr, 32'h100);
                chk("m_sw", din_w, 32'h1122_3344);
                chk("m_we1", {31'd0, mem_write_en}, 1);
              end
          4:  chk("m_we0", {31'd0, mem_write_en}, 0);
          5:  chk("m_sb", din_w, 32'h1122_33AA);
          9:  chk("m_lw", din_w, 32'h1122_33AA);
          10: chk("m_lb", din_w, 32'hFFFF_FFAA);
          11: chk("m_lbu", din_w, 32'h0000_00AA);
          14: chk("m_sh", din_w, 32'h33AA_00AA);
          16: chk("m_lw_mis", din_w, 32'hAA00_AA33);
          18: chk("m_lh_mis", din_w, 32'hFFFF_AA33);
          19: chk("m_lh", din_w, 32'h0000_33AA);
          20: chk("m_lhu", din_w, 32'h0000_1122);
          23: chk("m_halt", {31'd0, halted}, 1);
          default: ;
        endcase
        default: case (cyc)
          0:  chk("c_pc0", inst_addr, 0);
          2:  chk("c_beq", inst_addr, 32'h0c);
          3:  chk("c_bne", inst_addr, 32'h10);
          4:  chk("c_blt", inst_addr, 32'h18);
          7:  begin
                chk("c_jal_pc", inst_addr, 32'h30);
                chk("c_jal_rd", din_w, 32'h24);
              end
          10: chk("c_jalr", inst_addr, 32'h24);
          11: chk("c_j", inst_addr, 32'h40);
          12: begin
                chk("c_halt", {31'd0, halted}, 1);
                chk("c_hpc", inst_addr, 32'h40);
              end
          13: begin
                chk("c_hwe", {31'd0, mem_write_en}, 0);
                chk("c_hpc2", inst_addr, 32'h40);
              end
          default: ;
        endcase
      endcase

      if (wb && rd != 0) m_x[rd] = wv;
      for (int k = 0; k < n; k++)
        m_mem[ea[9:0] + 10'(k)] = e_din[8*k +: 8];
      m_pc = npc;
      if (hnow) m_halt = 1;
      cyc++;
    end
  end

  int len [0:2] = '{40, 24, 16};

  initial begin
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      #1;
      rst_b = 1'b0;
      prog = p;
      load(p);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst_b = 1'b1;
      repeat (len[p]) @(negedge clk);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
